// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage program-counter sequencer.
package pc_pkg;

    localparam int unsigned PC_W_DEF      = 32;
    localparam int unsigned STEP_DEF      = 4;
    localparam int unsigned ALIGN_B_DEF   = 2;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    // Next-pc source, one per priority level
    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_BR   = 3'd3,
        SEL_EXC  = 3'd4
    } pc_sel_e;

endpackage : pc_pkg

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] top_c,
    output logic            empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] ptr_pop;
    logic [CNT_W-1:0] cnt_pop;
    logic             do_pop;

    assign empty_c = (cnt_q == '0);
    assign top_c   = mem_q[ptr_q - PTR_W'(1)];
    assign do_pop  = pop_i && !empty_c;

    // Pop is applied first so a same-cycle pop+push replaces the top entry
    assign ptr_pop = do_pop ? ptr_q - PTR_W'(1) : ptr_q;
    assign cnt_pop = do_pop ? cnt_q - CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[ptr_pop] <= push_data_i;
            ptr_q          <= ptr_pop + PTR_W'(1);
            cnt_q          <= (cnt_pop == CNT_MAX) ? CNT_MAX : cnt_pop + CNT_W'(1);
        end else begin
            ptr_q <= ptr_pop;
            cnt_q <= cnt_pop;
        end
    end

endmodule : pc_ras

// File: rtl/pc_sequencer.sv
// IF-stage program counter: IDLE/RUN control, stall hold and prioritised aligned redirects.
// Define PC_RAS_EN to add the return-address stack behind call/return jumps.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     STEP      = STEP_DEF,
    parameter int unsigned     ALIGN_B   = ALIGN_B_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0080),
    parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            exc_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [PC_W-1:0] jmp_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [PC_W-1:0] pc_o,
    output logic            valid_o,
    output logic            misalign_o
);

    localparam logic [PC_W-1:0] ALIGN_MASK = {PC_W{1'b1}} << ALIGN_B;
    localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    pc_sel_e         sel;
    logic [PC_W-1:0] raw_tgt;
    logic [PC_W-1:0] jmp_tgt_c;
    logic [PC_W-1:0] pc_seq_c;

    assign pc_seq_c = pc_q + STEP_V;

`ifdef PC_RAS_EN
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ras_push;
    logic            ras_pop;

    // Stack only moves when the jump actually wins priority
    assign ras_push  = (sel == SEL_JMP) && call_i;
    assign ras_pop   = (sel == SEL_JMP) && ret_i;
    assign jmp_tgt_c = (ret_i && !ras_empty) ? ras_top : jmp_target_i;

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_seq_c),
        .top_c       (ras_top),
        .empty_c     (ras_empty)
    );
`else
    logic        unused_ras;
    logic [31:0] unused_depth;

    assign jmp_tgt_c    = jmp_target_i;
    assign unused_ras   = call_i ^ ret_i;
    assign unused_depth = 32'(RAS_DEPTH);
`endif

    // Next-state, priority select and next-pc computation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        sel        = SEL_HOLD;
        raw_tgt    = pc_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            default: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                    if (exc_i)           sel = SEL_EXC;
                    else if (br_taken_i) sel = SEL_BR;
                    else if (jmp_i)      sel = SEL_JMP;
                    else if (stall_i)    sel = SEL_HOLD;
                    else                 sel = SEL_SEQ;
                end
            end
        endcase

        case (sel)
            SEL_EXC: raw_tgt = EXC_VEC;
            SEL_BR:  raw_tgt = br_target_i;
            SEL_JMP: raw_tgt = jmp_tgt_c;
            default: raw_tgt = pc_q;
        endcase

        if (sel == SEL_EXC || sel == SEL_BR || sel == SEL_JMP) begin
            pc_d       = raw_tgt & ALIGN_MASK;
            misalign_d = |(raw_tgt & ~ALIGN_MASK);
        end else if (sel == SEL_SEQ) begin
            pc_d = pc_seq_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign valid_o    = valid_q;
    assign misalign_o = misalign_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with an expected-output scoreboard queue.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        exc_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_target_i = '0;
    logic        call_i = 1'b0;
    logic        ret_i = 1'b0;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start, stall, exc, br, jmp, call, ret;
        logic [31:0] br_t, jmp_t;
        logic [31:0] exp_pc;
        logic        exp_valid, exp_mis;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    pc_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .exc_i        (exc_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .call_i       (call_i),
        .ret_i        (ret_i),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(logic st, logic sl, logic ex, logic br, logic [31:0] brt,
                                logic jp, logic [31:0] jpt, logic cl, logic rt,
                                logic [31:0] epc, logic ev, logic em);
        vec_t v;
        v.start = st; v.stall = sl; v.exc = ex; v.br = br; v.br_t = brt;
        v.jmp = jp; v.jmp_t = jpt; v.call = cl; v.ret = rt;
        v.exp_pc = epc; v.exp_valid = ev; v.exp_mis = em;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one vector after a rising edge, then compare the registered result one edge later
    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        start_i = v.start; stall_i = v.stall; exc_i = v.exc;
        br_taken_i = v.br; br_target_i = v.br_t;
        jmp_i = v.jmp; jmp_target_i = v.jmp_t; call_i = v.call; ret_i = v.ret;
        sb_q.push_back('{pc: v.exp_pc, valid: v.exp_valid, mis: v.exp_mis});
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        check({nm, ".pc"}, pc_o, e.pc);
        check({nm, ".valid"}, 32'(valid_o), 32'(e.valid));
        check({nm, ".misalign"}, 32'(misalign_o), 32'(e.mis));
    endtask

    initial begin
        #2;
        check("reset.pc", pc_o, 32'h0);
        check("reset.valid", 32'(valid_o), 32'h0);
        check("reset.misalign", 32'(misalign_o), 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        //        st sl ex br br_t          jp jmp_t         cl rt exp_pc        v  m
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0004, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0008, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_000C, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0014, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 32'h200,      1, 32'h300,      0, 0, 32'h0000_0200, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 32'h200,      1, 32'h300,      0, 0, 32'h0000_0080, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 32'h103,      0, 32'h0,        0, 0, 32'h0000_0100, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0104, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h302,      0, 0, 32'h0000_0300, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h500,      0, 32'h0,        0, 0, 32'h0000_0300, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h600,      1, 32'h700,      0, 0, 32'h0000_0300, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0300, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0304, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0004, 1, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Asynchronous reset mid-RUN must clear outputs without a clock edge
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h40, 0, 0, 32'h40, 1, 0), "to40");
        rst_i = 1'b1;
        #1;
        check("async_rst.pc", pc_o, 32'h0);
        check("async_rst.valid", 32'(valid_o), 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0), "idle_after_rst");
        apply(mk(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1, 0), "restart");
        apply(mk(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h4, 1, 0), "restart_seq");

`ifdef PC_RAS_EN
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h20,   0, 0, 32'h20,   1, 0), "ras_to20");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h400,  1, 0, 32'h400,  1, 0), "ras_call");
        apply(mk(1, 0, 0, 0, 32'h0, 0, 32'h0,    0, 0, 32'h404,  1, 0), "ras_body");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h700,  0, 1, 32'h24,   1, 0), "ras_ret");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h1000, 1, 0, 32'h1000, 1, 0), "call1");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h2000, 1, 0, 32'h2000, 1, 0), "call2");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h3000, 1, 0, 32'h3000, 1, 0), "call3");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h4000, 1, 0, 32'h4000, 1, 0), "call4");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h5000, 1, 0, 32'h5000, 1, 0), "call5");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h9000, 0, 1, 32'h4004, 1, 0), "ret1");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h9000, 0, 1, 32'h3004, 1, 0), "ret2");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h9000, 0, 1, 32'h2004, 1, 0), "ret3");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h9000, 0, 1, 32'h1004, 1, 0), "ret4");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h9000, 0, 1, 32'h9000, 1, 0), "ret5_empty");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'hA000, 1, 0, 32'hA000, 1, 0), "callA");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'hB000, 1, 1, 32'h9004, 1, 0), "call_ret");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'hC000, 0, 1, 32'hA004, 1, 0), "ret_after_swap");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'hC000, 0, 1, 32'hC000, 1, 0), "ret_empty2");
        apply(mk(1, 0, 0, 1, 32'hD000, 1, 32'hE000, 1, 0, 32'hD000, 1, 0), "call_lost");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'hF000, 0, 1, 32'hF000, 1, 0), "ret_no_push");
`else
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h400, 1, 0, 32'h400, 1, 0), "call_plain");
        apply(mk(1, 0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h404, 1, 0), "call_body");
        apply(mk(1, 0, 0, 0, 32'h0, 1, 32'h500, 0, 1, 32'h500, 1, 0), "ret_plain");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_sequencer
